// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Width-parametrised pipeline stage register with a valid/ready handshake
//   and a one-entry skid buffer. in_ready, out_valid and out_data come only
//   from registers, so there is no combinational path from out_ready to
//   in_ready. One transfer per cycle is sustained while out_ready is high.
//
// Parameters
//   DATA_W     payload width
//   CNT_W      performance counter width
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset (highest priority)
//   flush      squash all held entries (priority over the handshake)
//   in_valid   upstream has data
//   in_ready   stage can accept data (low only when the skid entry is used)
//   in_data    upstream payload
//   out_valid  main entry holds data for downstream
//   out_ready  downstream accepts
//   out_data   payload of the main entry
//   stall_cnt  cycles with out_valid & !out_ready (saturating)
//   bubble_cnt cycles with !out_valid & out_ready (saturating)
//
// Build option
//   PIPE_STAGE_PERF_EN  when defined, the stall/bubble counters are built;
//                       they clear on rst only. When undefined both counter
//                       outputs are tied to zero.

module pipe_stage_skid #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // State encoding is {skid_v, main_v}; 2'b10 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic              main_v;
    logic              skid_v;
    logic              in_fire;
    logic              out_fire;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;

    assign main_v    = state_q[0];
    assign skid_v    = state_q[1];
    assign in_ready  = ~skid_v;
    assign out_valid = main_v;
    assign out_data  = main_data;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    load_main_in = 1'b1;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire && !out_ready) begin
                    // Downstream stalled while a beat was accepted: park it.
                    load_skid = 1'b1;
                    state_d   = FULL;
                end else if (!in_fire && out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    load_main_skid = 1'b1;
                    state_d        = BUSY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        // A flush drops any beat accepted this cycle; the main entry's
        // out_fire (if any) has already been consumed downstream.
        if (flush) begin
            state_d        = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            main_data <= '0;
            skid_data <= '0;
        end else begin
            state_q <= state_d;
            if (load_main_in) begin
                main_data <= in_data;
            end else if (load_main_skid) begin
                main_data <= skid_data;
            end
            if (load_skid) begin
                skid_data <= in_data;
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] bubble_q;

    // Counters see the pre-edge handshake, flush cycles included.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (!out_valid && out_ready && (bubble_q != '1)) begin
                bubble_q <= bubble_q + 1'b1;
            end
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule
